// File: rtl/dvp_frame_tx_if.sv
// dvp_frame_tx_if: upstream pixel stream and DVP byte bus of the camera emulator
interface dvp_frame_tx_if;
  logic [15:0] pix_in;
  logic        pix_in_valid;
  logic        pix_in_ready;
  logic        vsync;
  logic        href;
  logic [7:0]  p_data;
  modport master (input pix_in, pix_in_valid, output pix_in_ready, vsync, href, p_data);
  modport slave (output pix_in, pix_in_valid, input pix_in_ready, vsync, href, p_data);
endinterface

// File: rtl/dvp_frame_tx.sv
// dvp_frame_tx: OV7670-style DVP frame transmitter fed by a pixel stream or a test pattern
module dvp_frame_tx #(
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter int          H_BLANK     = 144,
  parameter int          VSYNC_LINES = 3,
  parameter int          V_BP_LINES  = 17,
  parameter int          V_FP_LINES  = 10,
  parameter logic [15:0] FILL        = 16'h0000
) (
  input  logic          p_clock,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [1:0]    pattern_sel,
  input  logic          underrun_clr,
  dvp_frame_tx_if.master bus,
  output logic          frame_start,
  output logic          frame_end,
  output logic          underrun,
  output logic [15:0]   frame_count
);
  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;
  localparam logic [15:0]  L_LAST   = 16'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0]  H_BYTES  = 16'(2 * H_ACTIVE);
  localparam logic [15:0]  VS_LAST  = 16'(VSYNC_LINES - 1);
  localparam logic [15:0]  BP_LAST  = 16'(V_BP_LINES - 1);
  localparam logic [15:0]  ACT_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0]  FP_LAST  = 16'(V_FP_LINES - 1);
  localparam logic [127:0] BARS     = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                       16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
  state_t      r_state, w_next;
  logic [15:0] r_h, r_v, r_fc, w_pix;
  logic [1:0]  r_pat;
  logic [7:0]  r_lo, r_data, w_data;
  logic [2:0]  w_bar;
  logic        r_vsync, r_href, r_fs, r_fe, r_und;
  logic        w_le, w_end, w_vsync, w_href, w_even, w_ready, w_fs, w_fe;
  always_ff @(posedge p_clock or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_h     <= '0;
      r_v     <= '0;
    end else begin
      r_state <= w_next;
      r_h     <= (w_next != r_state || r_state == IDLE || w_le) ? '0 : r_h + 16'd1;
      r_v     <= (w_next != r_state || r_state == IDLE) ? '0 : r_v + 16'(w_le);
    end
  always_comb begin
    w_le  = r_h == L_LAST;
    w_end = w_le && r_v == (r_state == VSYNC ? VS_LAST : r_state == VBP ? BP_LAST :
                            r_state == ACTIVE ? ACT_LAST : FP_LAST);
    case (r_state)
      IDLE:    w_next = enable ? VSYNC : IDLE;
      VSYNC:   w_next = w_end ? VBP : VSYNC;
      VBP:     w_next = w_end ? ACTIVE : VBP;
      ACTIVE:  w_next = w_end ? VFP : ACTIVE;
      default: w_next = w_end ? (enable ? VSYNC : IDLE) : VFP;
    endcase
  end
  // Counters describe the byte launched at the next edge, so the decode feeds the output registers.
  always_comb begin
    w_href  = r_state == ACTIVE && r_h < H_BYTES;
    w_even  = w_href && !r_h[0];
    w_ready = w_even && r_pat == 2'd0;
    w_bar   = 3'((32'(r_h[15:1]) * 8) / H_ACTIVE);
    w_pix   = r_pat == 2'd1 ? BARS[{w_bar, 4'b0} +: 16] :
              r_pat == 2'd2 ? {r_v[7:0], r_h[8:1]} :
              r_pat == 2'd3 ? FILL :
              bus.pix_in_valid ? bus.pix_in : FILL;
    w_data  = !w_href ? 8'h00 : r_h[0] ? r_lo : w_pix[15:8];
    w_vsync = r_state == IDLE || r_state == VSYNC;
    w_fs    = r_state == VSYNC && r_h == '0 && r_v == '0;
    w_fe    = r_state == VFP && w_end;
  end
  always_ff @(posedge p_clock or negedge rst_n)
    if (!rst_n) begin
      r_vsync <= 1'b1;
      r_href  <= 1'b0;
      r_data  <= '0;
      r_fs    <= 1'b0;
      r_fe    <= 1'b0;
      r_und   <= 1'b0;
      r_fc    <= '0;
      r_pat   <= '0;
      r_lo    <= '0;
    end else begin
      r_vsync <= w_vsync;
      r_href  <= w_href;
      r_data  <= w_data;
      r_fs    <= w_fs;
      r_fe    <= w_fe;
      r_und   <= (w_ready && !bus.pix_in_valid) || (r_und && !underrun_clr);
      r_fc    <= r_fc + 16'(w_fe);
      if (w_fs) r_pat <= pattern_sel;
      if (w_even) r_lo <= w_pix[7:0];
    end
  assign bus.pix_in_ready = w_ready;
  assign bus.vsync        = r_vsync;
  assign bus.href         = r_href;
  assign bus.p_data       = r_data;
  assign frame_start      = r_fs;
  assign frame_end        = r_fe;
  assign underrun         = r_und;
  assign frame_count      = r_fc;
endmodule
